// File: rtl/mips_pkg.sv
// mips_pkg: shared state, opcode, funct, aluop and alucontrol encodings for the TinyMIPS control path
package mips_pkg;
    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] AC_AND = 3'b000;
    localparam logic [2:0] AC_OR  = 3'b001;
    localparam logic [2:0] AC_ADD = 3'b010;
    localparam logic [2:0] AC_SUB = 3'b110;
    localparam logic [2:0] AC_SLT = 3'b111;
endpackage

// File: rtl/controller_aludec.sv
// aludec: maps aluop and funct to the 3-bit ALU operation code
//   aluop      in  2  add / sub / use funct
//   funct      in  6  instr[5:0]
//   alucontrol out 3  ALU operation
module aludec
    import mips_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);
    logic [2:0] fn_ac;

    always_comb begin
        fn_ac = funct == FN_SUB ? AC_SUB :
                funct == FN_AND ? AC_AND :
                funct == FN_OR  ? AC_OR  :
                funct == FN_SLT ? AC_SLT : AC_ADD;
        alucontrol = aluop == ALUOP_FUNCT ? fn_ac :
                     aluop == ALUOP_SUB   ? AC_SUB : AC_ADD;
    end
endmodule

// File: rtl/controller.sv
// controller: multicycle Moore FSM sequencing byte-wise fetch, decode, execute and writeback
//   clk, reset (async, active-low)
//   op, funct, zero              from datapath
//   memread, memwrite, alusrca, alusrcb, iord, irwrite, memtoreg,
//   regdst, regwrite, pcsource, pcen, alucontrol   to datapath
module controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic [1:0] pcsource,
    output logic       pcen,
    output logic [2:0] alucontrol
);
    state_t state_q, state_d;
    aluop_t aluop;
    logic   pcwrite, pcwritecond;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= S_FETCH1;
        else        state_q <= state_d;

    always_comb begin
        state_d     = S_FETCH1;
        aluop       = ALUOP_ADD;
        memread     = 1'b0;
        memwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        iord        = 1'b0;
        irwrite     = 4'b0000;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        pcsource    = 2'b00;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        case (state_q)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                irwrite = 4'b0001 << state_q[1:0];
                state_d = state_q == S_FETCH4 ? S_DECODE : state_t'(state_q + 4'd1);
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                state_d = op == OP_LB || op == OP_SB ? S_MEMADR  :
                          op == OP_RTYPE             ? S_RTYPEEX :
                          op == OP_BEQ               ? S_BEQEX   :
                          op == OP_J                 ? S_JEX     : S_FETCH1;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = op == OP_LB ? S_LBRD : S_SBWR;
            end
            S_LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                state_d = S_LBWR;
            end
            S_LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_RTYPEWR;
            end
            S_RTYPEWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQEX: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            S_JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            default: state_d = S_FETCH1;
        endcase
    end

    // Branch enable follows zero combinationally so the PC only moves on a taken BEQ.
    assign pcen = pcwrite | (pcwritecond & zero);

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );
endmodule

// File: tb/tb_controller.sv
// tb_controller: directed-vector self-checking bench for controller
module tb_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] irwrite;
    logic [2:0] alucontrol;
    int total = 0;
    int bad = 0;

    controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memread    (memread),
        .memwrite   (memwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .iord       (iord),
        .irwrite    (irwrite),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .pcsource   (pcsource),
        .pcen       (pcen),
        .alucontrol (alucontrol)
    );

    always #5 clk = ~clk;

    // {memread,memwrite,alusrca,alusrcb,iord,irwrite,memtoreg,regdst,regwrite,pcsource,pcen,alucontrol}
    logic [18:0] obs;
    assign obs = {memread, memwrite, alusrca, alusrcb, iord, irwrite,
                  memtoreg, regdst, regwrite, pcsource, pcen, alucontrol};

    function automatic logic [18:0] ex(input logic mr, mw, sa, input logic [1:0] sb,
                                       input logic io, input logic [3:0] ir,
                                       input logic mt, rd, rw, input logic [1:0] ps,
                                       input logic pe, input logic [2:0] ac);
        return {mr, mw, sa, sb, io, ir, mt, rd, rw, ps, pe, ac};
    endfunction

    task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [18:0] exp);
        @(posedge clk);
        #1;
        chk(tag, obs, exp);
    endtask

    task automatic fetch(input string tag);
        step({tag, "_f2"},  ex(1,0,0,2'b01,0,4'b0010,0,0,0,2'b00,1,3'b010));
        step({tag, "_f3"},  ex(1,0,0,2'b01,0,4'b0100,0,0,0,2'b00,1,3'b010));
        step({tag, "_f4"},  ex(1,0,0,2'b01,0,4'b1000,0,0,0,2'b00,1,3'b010));
        step({tag, "_dec"}, ex(0,0,0,2'b11,0,4'b0000,0,0,0,2'b00,0,3'b010));
    endtask

    logic [18:0] x_f1, x_rwr, x_ma, x_lbrd, x_lbwr, x_sbwr, x_jex;

    task automatic rtype(input string tag, input logic [5:0] fn, input logic [2:0] ac);
        op = 6'b000000;
        funct = fn;
        fetch(tag);
        step({tag, "_ex"}, ex(0,0,1,2'b00,0,4'b0000,0,0,0,2'b00,0,ac));
        step({tag, "_wr"}, x_rwr);
        step({tag, "_f1"}, x_f1);
    endtask

    task automatic beq(input string tag, input logic z);
        op = 6'b000100;
        funct = 6'd0;
        zero = 1'b1;
        fetch(tag);
        zero = z;
        #1;
        chk({tag, "_ex0"}, obs, ex(0,0,0,2'b11,0,4'b0000,0,0,0,2'b00,0,3'b010));
        step({tag, "_ex"}, ex(0,0,1,2'b00,0,4'b0000,0,0,0,2'b01,z,3'b110));
        zero = ~z;
        #1;
        chk({tag, "_exflip"}, obs, ex(0,0,1,2'b00,0,4'b0000,0,0,0,2'b01,~z,3'b110));
        step({tag, "_f1"}, x_f1);
        zero = 1'b0;
    endtask

    initial begin
        x_f1   = ex(1,0,0,2'b01,0,4'b0001,0,0,0,2'b00,1,3'b010);
        x_rwr  = ex(0,0,0,2'b00,0,4'b0000,0,1,1,2'b00,0,3'b010);
        x_ma   = ex(0,0,1,2'b10,0,4'b0000,0,0,0,2'b00,0,3'b010);
        x_lbrd = ex(1,0,0,2'b00,1,4'b0000,0,0,0,2'b00,0,3'b010);
        x_lbwr = ex(0,0,0,2'b00,0,4'b0000,1,0,1,2'b00,0,3'b010);
        x_sbwr = ex(0,1,0,2'b00,1,4'b0000,0,0,0,2'b00,0,3'b010);
        x_jex  = ex(0,0,0,2'b00,0,4'b0000,0,0,0,2'b10,1,3'b010);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", obs, x_f1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_f1", obs, x_f1);

        rtype("radd", 6'b100000, 3'b010);
        rtype("rslt", 6'b101010, 3'b111);
        rtype("rand", 6'b100100, 3'b000);
        rtype("rsub", 6'b100010, 3'b110);
        rtype("ror",  6'b100101, 3'b001);
        rtype("runk", 6'b111111, 3'b010);

        op = 6'b100000;
        fetch("lb");
        step("lb_ma", x_ma);
        step("lb_rd", x_lbrd);
        step("lb_wr", x_lbwr);
        step("lb_f1", x_f1);

        op = 6'b101000;
        fetch("sb");
        step("sb_ma", x_ma);
        step("sb_wr", x_sbwr);
        step("sb_f1", x_f1);

        beq("beq1", 1'b1);
        beq("beq0", 1'b0);

        op = 6'b000010;
        fetch("j");
        step("j_ex", x_jex);
        step("j_f1", x_f1);

        op = 6'b111111;
        fetch("ill");
        step("ill_f1", x_f1);

        op = 6'b000000;
        funct = 6'b100000;
        fetch("mid");
        step("mid_ex", ex(0,0,1,2'b00,0,4'b0000,0,0,0,2'b00,0,3'b010));
        step("mid_wr", x_rwr);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst", obs, x_f1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rel", obs, x_f1);
        fetch("post");
        step("post_ex", ex(0,0,1,2'b00,0,4'b0000,0,0,0,2'b00,0,3'b010));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
